// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame -- PS/2 device-to-host frame receiver.
//
// Synchronises and deglitches the raw PS/2 clock/data lines, then deserialises
// one 11-bit frame (start, 8 data bits LSB first, odd parity, stop) per
// falling edge of the filtered clock. A good frame updates dout and pulses
// rx_done_tick. A bad stop bit or a mid-frame inactivity timeout pulses
// frame_err instead.
//
// Optional build macro: PS2_PARITY_CHECK_EN -- when defined, frames with
// even parity are also rejected via frame_err. Otherwise the parity bit is
// captured but ignored.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   ps2c, ps2d   raw PS/2 clock / data lines (asynchronous)
//   rx_en        gates acceptance of a new start bit only
//   rx_done_tick one-cycle pulse, a valid scan code is on dout
//   dout         last good scan code, held until the next good frame
//   frame_err    one-cycle pulse, frame dropped
//   rx_idle      high while the receiver waits for a start bit
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       rx_idle
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;

  state_t                state, state_n;
  logic [1:0]            c_sync, d_sync;
  logic [FILTER_LEN-1:0] filt;
  logic                  f_val, f_prev;
  logic [3:0]            n_reg, n_n;
  logic [9:0]            b_reg, b_n;
  logic [TO_W-1:0]       wd, wd_n;
  logic [7:0]            dout_q;
  logic                  fall_edge, d_s, frame_ok;

  assign d_s       = d_sync[1];
  assign fall_edge = f_prev & ~f_val;

  // Register layout after the stop bit: [9]=stop, [8]=parity, [7:0]=data.
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = b_reg[9] & (^b_reg[8:0]);
`else
  logic parity_unused;
  assign parity_unused = b_reg[8];
  assign frame_ok      = b_reg[9];
`endif

  // Input conditioning: 2-flop synchronisers, then a level filter on the
  // clock that only flips once the line has been stable for FILTER_LEN cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
      filt   <= '1;
      f_val  <= 1'b1;
      f_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      filt   <= {c_sync[1], filt[FILTER_LEN-1:1]};
      if (&filt)       f_val <= 1'b1;
      else if (~|filt) f_val <= 1'b0;
      f_prev <= f_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      n_reg  <= '0;
      b_reg  <= '0;
      wd     <= '0;
      dout_q <= '0;
    end else begin
      state  <= state_n;
      n_reg  <= n_n;
      b_reg  <= b_n;
      wd     <= wd_n;
      dout_q <= dout;
    end
  end

  always_comb begin
    state_n      = state;
    n_n          = n_reg;
    b_n          = b_reg;
    wd_n         = wd;
    dout         = dout_q;
    rx_done_tick = 1'b0;
    frame_err    = 1'b0;
    rx_idle      = 1'b0;
    case (state)
      IDLE: begin
        rx_idle = 1'b1;
        if (fall_edge && rx_en && !d_s) begin
          wd_n    = '0;
          n_n     = 4'd9;
          state_n = DPS;
        end
      end
      DPS: begin
        if (fall_edge) begin
          b_n  = {d_s, b_reg[9:1]};
          wd_n = '0;
          if (n_reg == 4'd0) state_n = LOAD;
          else               n_n     = n_reg - 4'd1;
        end else if (wd == TO_LAST) begin
          frame_err = 1'b1;
          state_n   = IDLE;
        end else begin
          wd_n = wd + 1'b1;
        end
      end
      LOAD: begin
        // dout is bypassed here so the new code is visible with the tick.
        state_n = IDLE;
        if (frame_ok) begin
          rx_done_tick = 1'b1;
          dout         = b_reg[7:0];
        end else begin
          frame_err = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
module tb_ps2_rx_frame;
  localparam int FL = 8;
  localparam int TO = 500;
  localparam int H  = 40;   // PS/2 half period in clk cycles (scaled down)
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, ps2c, ps2d, rx_en;
  logic       rx_done_tick, frame_err, rx_idle;
  logic [7:0] dout;

  always #5 clk = ~clk;

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .TO_W(18)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .rx_done_tick(rx_done_tick), .dout(dout), .frame_err(frame_err),
    .rx_idle(rx_idle)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts pulses and records dout at every tick.
  int         tick_cnt = 0, err_cnt = 0, both_cnt = 0, tick_cyc = 0, err_cyc = 0;
  int         tick_hi  = 0;
  logic [7:0] tick_q[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_done_tick) begin
        tick_cnt++; tick_cyc = cyc; tick_q.push_back(dout);
      end
      if (frame_err) begin err_cnt++; err_cyc = cyc; end
      if (rx_done_tick && frame_err) both_cnt++;
    end
  end

  int checks = 0, failures = 0, last_fall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bits go out LSB first; glitches pulse ps2c for 3 cycles in each phase.
  task automatic send_bits(input logic [10:0] bits, input int nbits,
                           input bit glitch, input bit drop_en);
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      if (glitch) begin
        wait_cyc(H/2); ps2c = 1'b0; wait_cyc(3); ps2c = 1'b1; wait_cyc(H/2 - 3);
      end else begin
        wait_cyc(H);
      end
      ps2c = 1'b0;
      last_fall = cyc;
      if (glitch) begin
        wait_cyc(H/2); ps2c = 1'b1; wait_cyc(3); ps2c = 1'b0; wait_cyc(H/2 - 3);
      end else begin
        wait_cyc(H);
      end
      if (i == 0 && drop_en) rx_en = 1'b0;
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit par_bad, input bit stop);
    logic p;
    p = (~^d) ^ par_bad;
    return {stop, p, d, 1'b0};
  endfunction

  typedef struct {
    logic [7:0] data;
    bit par_bad, stop, en, glitch;
    bit exp_tick, exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[9];
  int t0, e0, lat, dly;
  logic [7:0] model_dout;

  initial begin
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1;
    #1;
    chk("reset_idle", rx_idle, 1);
    chk("reset_dout", dout, 8'h00);
    chk("reset_tick", rx_done_tick, 0);
    chk("reset_err", frame_err, 0);
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(2 * H);   // idle line with a glitch
    ps2c = 1'b0; wait_cyc(3); ps2c = 1'b1; wait_cyc(H);

    vecs[0] = '{8'h1C, 0, 1, 1, 0, 1, 0, 8'h1C};
    vecs[1] = '{8'hF0, 0, 1, 1, 0, 1, 0, 8'hF0};
    vecs[2] = '{8'h1C, 0, 0, 1, 0, 0, 1, 8'hF0};
    vecs[3] = '{8'h1C, 1, 1, 1, 0, !PAR, PAR, PAR ? 8'hF0 : 8'h1C};
    vecs[4] = '{8'h1C, 0, 1, 1, 1, 1, 0, 8'h1C};
    vecs[5] = '{8'h55, 0, 1, 1, 1, 1, 0, 8'h55};
    vecs[6] = '{8'hAA, 0, 1, 0, 0, 0, 0, 8'h55};
    vecs[7] = '{8'h00, 0, 1, 1, 0, 1, 0, 8'h00};
    vecs[8] = '{8'hFF, 0, 1, 1, 0, 1, 0, 8'hFF};

    lat = 0;
    for (int i = 0; i < 9; i++) begin
      t0 = tick_cnt; e0 = err_cnt;
      rx_en = vecs[i].en;
      send_bits(mk_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop), 11, vecs[i].glitch, 0);
      wait_cyc(30);
      rx_en = 1'b1;
      chk($sformatf("v%0d_tick", i), tick_cnt - t0, vecs[i].exp_tick);
      chk($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      chk($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
      if (vecs[i].exp_tick && tick_cnt > t0)
        chk($sformatf("v%0d_tickdout", i), tick_q[$], vecs[i].exp_dout);
      if (i == 0) lat = tick_cyc - last_fall;
    end
    chk("lat_range", (lat >= FL + 2 && lat <= FL + 6), 1);

    // Back-to-back frames.
    t0 = tick_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'hF0, 0, 1), 11, 0, 0);
    send_bits(mk_frame(8'h1C, 0, 1), 11, 0, 0);
    wait_cyc(30);
    chk("b2b_ticks", tick_cnt - t0, 2);
    chk("b2b_err", err_cnt - e0, 0);
    if (tick_cnt - t0 == 2) begin
      chk("b2b_first", tick_q[$-1], 8'hF0);
      chk("b2b_second", tick_q[$], 8'h1C);
    end

    // Timeout after 5 bits.
    t0 = tick_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h1C, 0, 1), 5, 0, 0);
    chk("to_busy", rx_idle, 0);
    for (int k = 0; k < TO + 200 && err_cnt == e0; k++) @(negedge clk);
    chk("to_err", err_cnt - e0, 1);
    dly = err_cyc - last_fall;
    chk("to_delay", dly, lat - 1 + TO);
    chk("to_idle", rx_idle, 1);
    chk("to_dout", dout, 8'h1C);
    send_bits(mk_frame(8'hF0, 0, 1), 11, 0, 0);
    wait_cyc(30);
    chk("to_next_tick", tick_cnt - t0, 1);
    chk("to_next_dout", dout, 8'hF0);

    // Reset mid-frame.
    t0 = tick_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h1C, 0, 1), 4, 0, 0);
    chk("rst_busy", rx_idle, 0);
    reset = 1'b1;
    #1;
    chk("rst_idle", rx_idle, 1);
    chk("rst_dout", dout, 8'h00);
    chk("rst_tick", rx_done_tick, 0);
    chk("rst_err", frame_err, 0);
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(TO + 100);
    chk("rst_no_pulse", (tick_cnt - t0) + (err_cnt - e0), 0);

    // rx_en dropped after the start bit: frame still completes.
    t0 = tick_cnt;
    send_bits(mk_frame(8'h1C, 0, 1), 11, 0, 1);
    wait_cyc(30);
    rx_en = 1'b1;
    chk("drop_en_tick", tick_cnt - t0, 1);
    chk("drop_en_dout", dout, 8'h1C);

    // Random frames against a behavioural model.
    model_dout = 8'h1C;
    for (int r = 0; r < 16; r++) begin
      logic [7:0] d;
      bit pb, st, good;
      d  = 8'($urandom);
      pb = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) != 0);
      good = st && !(PAR && pb);
      if (good) model_dout = d;
      t0 = tick_cnt; e0 = err_cnt;
      send_bits(mk_frame(d, pb, st), 11, ($urandom_range(0, 1) == 1), 0);
      wait_cyc(30);
      chk($sformatf("r%0d_tick", r), tick_cnt - t0, good);
      chk($sformatf("r%0d_err", r), err_cnt - e0, !good);
      chk($sformatf("r%0d_dout", r), dout, model_dout);
    end

    chk("tick_err_overlap", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
PS/2 device-to-host receiver that sits directly upstream of the key-recognition FSM in the keyboard controller. It synchronises and deglitches the raw PS/2 clock and data lines, then deserialises one 11-bit frame: start, 8 data bits LSB first, odd parity, stop. Each good frame produces an 8-bit scan code on dout with a single-cycle rx_done_tick. It also provides frame-error reporting and an inactivity watchdog.

Parameters:
FILTER_LEN, 8, length in clk cycles of the ps2c deglitch filter; the line must be stable this long to change the filtered level.
TIMEOUT_CYCLES, 200000, clk cycles without a falling edge mid-frame before the frame is aborted (2 ms at 100 MHz).
TO_W, 18, watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2c  in  1  raw PS/2 clock line, asynchronous
ps2d  in  1  raw PS/2 data line, asynchronous
rx_en  in  1  receive enable; gates acceptance of a new start bit only
rx_done_tick  out  1  one-cycle pulse: a valid frame is on dout
dout  out  8  last good scan code; held until the next good frame
frame_err  out  1  one-cycle pulse: frame dropped (bad stop bit, bad parity, or timeout)
rx_idle  out  1  high when the FSM is in idle

Behaviour:
- Reset values: rx_done_tick=0, dout=8'h00, frame_err=0, rx_idle=1, state=idle, filter=all 1s, filtered clock=1, shift register=0, bit counter=0, watchdog=0.
- Input conditioning:
  - ps2c and ps2d each pass through a 2-flop synchroniser.
  - Synchronised ps2c shifts into a FILTER_LEN-bit register.
  - The filtered clock goes to 1 when all bits are 1, goes to 0 when all bits are 0, and otherwise holds.
  - fall_edge = (previous filtered clock == 1) and (current filtered clock == 0). It is a single-cycle strobe.
- Data is sampled from synchronised ps2d on the fall_edge cycle.
- FSM states:
  - idle: rx_idle=1. On fall_edge with rx_en=1 and ps2d=0 (start bit): clear the watchdog, set the bit counter to 9, go to dps. A fall_edge with ps2d=1, or with rx_en=0, is ignored and the FSM stays in idle.
  - dps: on each fall_edge, shift ps2d into the MSB of a 10-bit register (right shift) and clear the watchdog.
    - If the counter is 0 on that edge, go to load. Otherwise decrement the counter.
    - With no edge, the watchdog increments. When it reaches TIMEOUT_CYCLES-1: pulse frame_err, go to idle, leave dout unchanged.
  - load: one cycle only. Register layout is [9]=stop, [8]=parity, [7:0]=data.
    - If stop==1 (and parity passes when checking is enabled): dout<=data and pulse rx_done_tick.
    - Otherwise pulse frame_err only.
    - Always return to idle.
- Latency: rx_done_tick and the new dout are visible in the cycle after the stop-bit fall_edge is detected. dout holds its value after the tick.
- rx_done_tick and frame_err are never asserted in the same cycle. Each is exactly one cycle wide.
- rx_en dropping mid-frame has no effect; the frame in progress completes normally.
- Reset asserted mid-frame returns the block to reset values immediately; the partial frame is discarded and no pulse is generated.
- A back-to-back start bit arriving in the cycle the FSM leaves load is accepted by idle on its next fall_edge. No frames are lost at PS/2 rates.

Optional Feature:
Macro PS2_PARITY_CHECK_EN.
- Defined: load additionally requires odd parity, i.e. XOR of data[7:0] and the parity bit equals 1. On parity failure: frame_err pulse, no rx_done_tick, dout unchanged.
- Undefined: the parity bit is captured but ignored; only the stop bit is checked.

Test Plan:
1. Send frame 0x1C (start 0; bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz -> one rx_done_tick, dout=8'h1C, frame_err stays 0.
2. Send 0xF0 (parity 1) followed immediately by 0x1C -> two ticks, dout=8'hF0 then 8'h1C, and the downstream break-code FSM flags the second frame.
3. Inject ps2c glitches shorter than FILTER_LEN-1 cycles during an idle line and mid-frame -> no extra bits, correct dout=8'h1C.
4. Send 0x1C with stop=0 -> frame_err pulse, no tick, dout keeps its previous value. With PS2_PARITY_CHECK_EN, send 0x1C with parity=1 -> same result. Without the macro -> tick, dout=8'h1C.
5. Stop ps2c after 5 bits -> frame_err exactly TIMEOUT_CYCLES after the last edge, rx_idle=1. The next full 0xF0 frame is received correctly.
6. Assert reset after 4 bits -> all outputs reach their reset values in the same cycle, no pulse. rx_en=0 during a start bit -> the frame is ignored, no tick.
